uart_reg_master: RTL and testbench

UART_REG_MASTER -- requirements
Module: uart_reg_master

---
 rtl/uart_reg_master.sv | 183 ++++++++++++++++++
 tb/tb_uart_reg_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_master.sv
// uart_reg_master: turns a byte stream from a UART receiver into register-bus
// reads and writes.
//
// Command: CMD ('W' 8'h57 / 'R' 8'h52), ADDR, LEN (0 means 256), then LEN data
// bytes for writes. Reads return LEN bytes on the tx side. The address
// auto-increments and wraps within a block.
//
// Ports:
//   clk, rst_n_sync          clock, asynchronous active-low reset
//   rx_data, rx_valid        received byte and its one-cycle strobe
//   tx_data, tx_valid        byte to transmitter, held until tx_ready
//   tx_ready                 transmitter accepts when tx_valid & tx_ready
//   address                  register-bus address
//   write_enable, write_data one-cycle register write strobe and data
//   read_enable, read_data   one-cycle read strobe, combinational read data
//   busy                     high whenever a command is in progress
//   cmd_timeout              one-cycle pulse when a partial command is dropped
//
// Optional feature: define UART_REG_MASTER_TIMEOUT_EN to compile in the
// inter-byte timeout (TIMEOUT_CYCLES). Without it, cmd_timeout is tied low and
// partial commands wait forever.
module uart_reg_master #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1200000
) (
    input  logic       clk,
    input  logic       rst_n_sync,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] address,
    output logic       write_enable,
    output logic [7:0] write_data,
    output logic       read_enable,
    input  logic [7:0] read_data,
    output logic       busy,
    output logic       cmd_timeout
);

    localparam logic [7:0] CmdWrite = 8'h57;
    localparam logic [7:0] CmdRead  = 8'h52;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetLen,
        StWrData,
        StWrStrobe,
        StRdStrobe,
        StRdSend
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] address_q, address_d;
    logic [7:0] write_data_q, write_data_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [8:0] count_q, count_d;
    logic       is_write_q, is_write_d;
    logic       tmo_hit;

`ifdef UART_REG_MASTER_TIMEOUT_EN
    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic        cmd_timeout_q;
    logic        waiting;

    // Only states that are waiting on the host for another byte can time out.
    assign waiting = (state_q == StGetAddr) || (state_q == StGetLen) || (state_q == StWrData);
    assign tmo_hit = waiting && !rx_valid && (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1);

    always_comb begin
        tmo_cnt_d = 24'd0;
        if (waiting && !rx_valid) begin
            tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            tmo_cnt_q     <= 24'd0;
            cmd_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            cmd_timeout_q <= tmo_hit;
        end
    end

    assign cmd_timeout = cmd_timeout_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign tmo_hit               = 1'b0;
    assign cmd_timeout           = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        tx_data_d    = tx_data_q;
        count_d      = count_q;
        is_write_d   = is_write_q;

        unique case (state_q)
            StIdle: begin
                if (rx_valid && (rx_data == CmdWrite || rx_data == CmdRead)) begin
                    is_write_d = (rx_data == CmdWrite);
                    state_d    = StGetAddr;
                end
            end
            StGetAddr: begin
                if (rx_valid) begin
                    address_d = rx_data;
                    state_d   = StGetLen;
                end
            end
            StGetLen: begin
                if (rx_valid) begin
                    count_d = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    state_d = is_write_q ? StWrData : StRdStrobe;
                end
            end
            StWrData: begin
                if (rx_valid) begin
                    write_data_d = rx_data;
                    state_d      = StWrStrobe;
                end
            end
            StWrStrobe: begin
                address_d = address_q + 8'd1;
                count_d   = count_q - 9'd1;
                state_d   = (count_q == 9'd1) ? StIdle : StWrData;
            end
            StRdStrobe: begin
                tx_data_d = read_data;
                state_d   = StRdSend;
            end
            StRdSend: begin
                if (tx_ready) begin
                    address_d = address_q + 8'd1;
                    count_d   = count_q - 9'd1;
                    state_d   = (count_q == 9'd1) ? StIdle : StRdStrobe;
                end
            end
            default: state_d = StIdle;
        endcase

        // An abandoned command drops back to idle; the pending byte never arrived,
        // so no strobe can follow.
        if (tmo_hit) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q      <= StIdle;
            address_q    <= 8'h00;
            write_data_q <= 8'h00;
            tx_data_q    <= 8'h00;
            count_q      <= 9'd0;
            is_write_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            tx_data_q    <= tx_data_d;
            count_q      <= count_d;
            is_write_q   <= is_write_d;
        end
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign write_enable = (state_q == StWrStrobe);
    assign read_enable  = (state_q == StRdStrobe);
    assign tx_valid     = (state_q == StRdSend);
    assign busy         = (state_q != StIdle);
    assign address      = address_q;
    assign write_data   = write_data_q;
    assign tx_data      = tx_data_q;

endmodule

// File: tb/tb_uart_reg_master.sv
// Self-checking bench for uart_reg_master: a 256-entry register bank answers the
// bus, a reference model predicts every register write and every tx byte, and a
// monitor compares DUT activity against the predicted queues.
module tb_uart_reg_master;

`ifdef UART_REG_MASTER_TIMEOUT_EN
    localparam logic [23:0] Tmo = 24'd100;
`else
    localparam logic [23:0] Tmo = 24'd1200000;
`endif

    logic       clk = 1'b0;
    logic       rst_n_sync = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [7:0] address;
    logic       write_enable;
    logic [7:0] write_data;
    logic       read_enable;
    logic [7:0] read_data;
    logic       busy;
    logic       cmd_timeout;

    uart_reg_master #(.TIMEOUT_CYCLES(Tmo)) dut (
        .clk          (clk),
        .rst_n_sync   (rst_n_sync),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .address      (address),
        .write_enable (write_enable),
        .write_data   (write_data),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .busy         (busy),
        .cmd_timeout  (cmd_timeout)
    );

    always #5 clk = ~clk;

    // Register bank seen by the DUT.
    logic [7:0] regs [256];
    assign read_data = regs[address];
    always @(posedge clk) begin
        if (write_enable) regs[address] <= write_data;
    end

    // Reference model and scoreboard.
    logic [7:0]  model [256];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  wq[$];
    int n_tests = 0;
    int n_fail = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int tmo_pulses = 0;
    int ready_mode = 0; // 0 always ready, 1 random, 2 held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // tx_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares every strobe / handshake against the predicted queues.
    initial begin
        logic [15:0] ew;
        logic [7:0]  et;
        forever begin
            @(negedge clk);
            if (rst_n_sync) begin
                if (write_enable) begin
                    wr_pulses++;
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write", 32'({address, write_data}), 32'hFFFF_FFFF);
                    end else begin
                        ew = exp_wr.pop_front();
                        check("write_addr_data", 32'({address, write_data}), 32'(ew));
                    end
                end
                if (read_enable) rd_pulses++;
                if (write_enable || read_enable) begin
                    check("strobe_exclusive_busy", 32'({write_enable & read_enable, ~busy}), 32'd0);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        check("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        et = exp_tx.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(et));
                    end
                end
                if (cmd_timeout) tmo_pulses++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, 32'(busy), 32'd0);
        check({name, "_wr_drained"}, 32'(exp_wr.size()), 32'd0);
        check({name, "_tx_drained"}, 32'(exp_tx.size()), 32'd0);
    endtask

    // Write n bytes taken from wq starting at address a.
    task automatic do_write(input logic [7:0] a, input int n, input string name);
        logic [7:0] d;
        logic [7:0] ai;
        send_byte(8'h57);
        send_byte(a);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            d  = wq.pop_front();
            ai = 8'((int'(a) + i) % 256);
            model[ai] = d;
            exp_wr.push_back({ai, d});
            send_byte(d);
        end
        wait_idle(name);
    endtask

    task automatic start_read(input logic [7:0] a, input int n, input bit predict);
        if (predict) begin
            for (int i = 0; i < n; i++) exp_tx.push_back(model[8'((int'(a) + i) % 256)]);
        end
        send_byte(8'h52);
        send_byte(a);
        send_byte(8'(n));
    endtask

    task automatic wait_tx_valid(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_valid) break;
        end
        check(name, 32'(tx_valid), 32'd1);
    endtask

    initial begin
        int rd_before;
        int wr_before;
        int tmo_before;
        logic [7:0] d0;
        bit stable;

        for (int i = 0; i < 256; i++) model[i] = 8'h00;

        // Reset state
        #3;
        check("reset_ctrl", 32'({busy, tx_valid, write_enable, read_enable, cmd_timeout}), 32'd0);
        check("reset_data", 32'({address, write_data, tx_data}), 32'd0);
        #30;
        rst_n_sync = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);

        // Fill the whole bank through the DUT (LEN=0 -> 256 transfers).
        for (int i = 0; i < 256; i++) wq.push_back(8'(i) ^ 8'h5A);
        do_write(8'h00, 256, "fill256");

        // Two-byte write at 03
        wq.push_back(8'hAA);
        wq.push_back(8'h55);
        do_write(8'h03, 2, "write_03");

        // Preload 0..5 = 10..15 then read them back with tx_ready held high.
        for (int i = 0; i < 6; i++) wq.push_back(8'h10 + 8'(i));
        do_write(8'h00, 6, "preload");
        rd_before = rd_pulses;
        start_read(8'h00, 6, 1'b1);
        wait_idle("read_6");
        check("read_6_pulses", 32'(rd_pulses - rd_before), 32'd6);

        // Wrap FF -> 00
        wq.push_back(8'h01);
        wq.push_back(8'h02);
        do_write(8'hFF, 2, "write_wrap");

        // Non-command byte in IDLE
        send_byte(8'h41);
        @(negedge clk);
        check("idle_0x41_busy", 32'(busy), 32'd0);

        // Back-pressure: tx_ready low 50 cycles, stray rx bytes must be dropped.
        ready_mode = 2;
        start_read(8'h02, 2, 1'b1);
        wait_tx_valid("hold_tx_valid");
        rd_before = rd_pulses;
        wr_before = wr_pulses;
        send_byte(8'h57);
        send_byte(8'h52);
        @(negedge clk);
        d0 = tx_data;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== d0) stable = 1'b0;
        end
        check("hold_stable", 32'(stable), 32'd1);
        check("hold_no_reread", 32'(rd_pulses - rd_before), 32'd0);
        check("hold_stray_no_write", 32'(wr_pulses - wr_before), 32'd0);
        ready_mode = 0;
        wait_idle("hold_read");

        // Randomised commands with random back-pressure
        ready_mode = 1;
        for (int c = 0; c < 24; c++) begin
            logic [7:0] a;
            int n;
            a = 8'($urandom);
            n = ($urandom_range(0, 9) == 0) ? 256 : int'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
                do_write(a, n, "rand_write");
            end else begin
                start_read(a, n, 1'b1);
                wait_idle("rand_read");
            end
        end
        ready_mode = 0;

`ifdef UART_REG_MASTER_TIMEOUT_EN
        // Partial command abandoned after TIMEOUT_CYCLES idle cycles.
        tmo_before = tmo_pulses;
        wr_before  = wr_pulses;
        send_byte(8'h57);
        send_byte(8'h05);
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        repeat (5) @(negedge clk);
        check("timeout_pulse", 32'(tmo_pulses - tmo_before), 32'd1);
        check("timeout_idle", 32'(busy), 32'd0);
        check("timeout_no_write", 32'(wr_pulses - wr_before), 32'd0);
`else
        // Partial command waits indefinitely; then complete it.
        tmo_before = tmo_pulses;
        send_byte(8'h57);
        send_byte(8'h05);
        repeat (200) @(negedge clk);
        check("no_timeout_busy", 32'(busy), 32'd1);
        check("no_timeout_pulse", 32'(tmo_pulses - tmo_before), 32'd0);
        model[8'h05] = 8'hC3;
        exp_wr.push_back({8'h05, 8'hC3});
        send_byte(8'h01);
        send_byte(8'hC3);
        wait_idle("late_finish");
`endif

        // Reset in the middle of a read: everything drops at once.
        ready_mode = 2;
        start_read(8'h40, 3, 1'b0);
        wait_tx_valid("prereset_tx_valid");
        #2;
        rst_n_sync = 1'b0;
        #1;
        check("midreset_ctrl", 32'({busy, tx_valid, write_enable, read_enable, cmd_timeout}), 32'd0);
        check("midreset_data", 32'({address, write_data, tx_data}), 32'd0);
        #20;
        rst_n_sync = 1'b1;
        ready_mode = 0;
        rd_before = rd_pulses;
        repeat (10) @(negedge clk);
        check("postreset_no_read", 32'(rd_pulses - rd_before), 32'd0);
        wait_idle("postreset");

        // Bank contents still readable and consistent after reset.
        start_read(8'hFE, 4, 1'b1);
        wait_idle("final_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
